// File: rtl/bm_sched_pkg.sv
// bm_sched_pkg: scheduler state encoding and default band geometry
package bm_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN, ST_DONE} bm_sched_state_t;
  localparam int DEF_NUM_BM = 2;
  localparam int DEF_THIRD_ROWS = 480;
  localparam int DEF_BAND_ROWS = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, search starts at ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    valid = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bm_read_scheduler.sv
// bm_read_scheduler: hands row bands of each completed image to idle block matchers
module bm_read_scheduler
  import bm_sched_pkg::*;
#(
  parameter int NUM_BM = DEF_NUM_BM,
  parameter int THIRD_ROWS = DEF_THIRD_ROWS,
  parameter int BAND_ROWS = DEF_BAND_ROWS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        image_number,
  input  logic [NUM_BM-1:0] bm_ready,
  input  logic [NUM_BM-1:0] bm_done,
  output logic [NUM_BM-1:0] bm_start,
  output logic [8:0]        bm_row,
  output logic              bm_buf,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt
);
  localparam int PW = NUM_BM > 1 ? $clog2(NUM_BM) : 1;
  localparam logic [4:0] LAST_BAND = 5'(THIRD_ROWS / BAND_ROWS - 1);
  bm_sched_state_t state, state_nxt;
  logic [3:0] img_q;
  logic last_buf, pending, evt, last_nxt, gnt_vld;
  logic [4:0] band;
  logic [NUM_BM-1:0] outstanding, live, req, gnt, out_nxt;
  logic [PW-1:0] rr_ptr, ptr_nxt;
  assign evt = image_number != img_q;
  assign last_nxt = last_buf ^ evt;
  assign live = outstanding & ~bm_done;
  assign req = state == ST_DISPATCH ? bm_ready & ~live : '0;
  assign out_nxt = live | gnt;
  rr_arbiter #(.N(NUM_BM), .PW(PW)) u_arb (
    .req  (req),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .valid(gnt_vld)
  );
  always_comb begin
    state_nxt = state;
    ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_BM; i++)
      if (gnt[i]) ptr_nxt = PW'((i + 1) % NUM_BM);
    unique case (state)
      ST_IDLE:     if (evt || pending) state_nxt = ST_DISPATCH;
      ST_DISPATCH: if (gnt_vld && band == LAST_BAND) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (out_nxt == '0) state_nxt = ST_DONE;
      default:     state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      img_q <= '0;
      last_buf <= 1'b1;
      pending <= 1'b0;
      band <= '0;
      outstanding <= '0;
      rr_ptr <= '0;
      bm_start <= '0;
      bm_row <= '0;
      bm_buf <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state <= state_nxt;
      img_q <= image_number;
      last_buf <= last_nxt;
      pending <= state != ST_IDLE && (pending || evt);
      if (evt && pending && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
      outstanding <= out_nxt;
      rr_ptr <= ptr_nxt;
      bm_start <= gnt;
      if (gnt_vld) bm_row <= 9'(band * BAND_ROWS);
      band <= state == ST_IDLE ? '0 : band + 5'(gnt_vld);
      if (state == ST_IDLE && (evt || pending)) bm_buf <= last_nxt;
      busy <= state_nxt != ST_IDLE;
      frame_done <= state == ST_DONE;
    end
  end
endmodule
